// File: rtl/drr_sched_pkg.sv
// Shared types and constants for the DRR output scheduler.
package drr_sched_pkg;

  localparam int DEF_NUM_QUEUES    = 5;
  localparam int DEF_LEN_WIDTH     = 16;
  localparam int DEF_QUANTUM_WIDTH = 16;

  typedef enum logic {
    SCAN  = 1'b0,
    SERVE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    BANK_NOP = 2'd0,
    BANK_ADD = 2'd1,
    BANK_SUB = 2'd2,
    BANK_CLR = 2'd3
  } bank_op_e;

  // Ceiling log2, never below 1 so single-queue builds still get a select bit.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/drr_deficit_bank.sv
// Per-queue deficit registers behind one shared port: saturating add,
// subtract and clear, all addressed by idx. rd_data is the current value.
module drr_deficit_bank
  import drr_sched_pkg::*;
#(
  parameter int NUM_QUEUES    = DEF_NUM_QUEUES,
  parameter int DEFICIT_WIDTH = DEF_LEN_WIDTH + 1,
  parameter int IDX_WIDTH     = log2_ceil(DEF_NUM_QUEUES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  bank_op_e                 op,
  input  logic [IDX_WIDTH-1:0]     idx,
  input  logic [DEFICIT_WIDTH-1:0] operand,
  output logic [DEFICIT_WIDTH-1:0] rd_data
);

  logic [DEFICIT_WIDTH-1:0] deficit_q [NUM_QUEUES];
  logic [DEFICIT_WIDTH-1:0] deficit_d [NUM_QUEUES];
  logic [DEFICIT_WIDTH:0]   sum;

  // Read mux for the addressed queue.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (idx == IDX_WIDTH'(i)) rd_data = deficit_q[i];
    end
  end

  // Next value: only the addressed entry can change; adds clamp at all-ones.
  always_comb begin
    sum = {1'b0, rd_data} + {1'b0, operand};
    for (int i = 0; i < NUM_QUEUES; i++) begin
      deficit_d[i] = deficit_q[i];
      if (idx == IDX_WIDTH'(i)) begin
        case (op)
          BANK_ADD: deficit_d[i] = sum[DEFICIT_WIDTH] ? '1 : sum[DEFICIT_WIDTH-1:0];
          BANK_SUB: deficit_d[i] = deficit_q[i] - operand;
          BANK_CLR: deficit_d[i] = '0;
          default:  deficit_d[i] = deficit_q[i];
        endcase
      end
    end
  end

  // Register array, cleared on reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (rst) deficit_q[i] <= '0;
      else     deficit_q[i] <= deficit_d[i];
    end
  end

endmodule

// File: rtl/drr_output_scheduler.sv
// Deficit-round-robin packet scheduler for the output-queue mux.
// Optional build macro: DRR_STRICT_HIPRI_EN makes the last queue (dma)
// strict priority and removes it from the DRR rotation.
module drr_output_scheduler
  import drr_sched_pkg::*;
#(
  parameter int NUM_QUEUES    = DEF_NUM_QUEUES,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int QUANTUM_WIDTH = DEF_QUANTUM_WIDTH,
  parameter int DEFICIT_WIDTH = LEN_WIDTH + 1
) (
  input  logic                                axis_aclk,
  input  logic                                axis_reset,
  input  logic [NUM_QUEUES-1:0]               q_nonempty,
  input  logic [NUM_QUEUES*LEN_WIDTH-1:0]     q_pkt_len,
  input  logic [NUM_QUEUES*QUANTUM_WIDTH-1:0] q_quantum,
  input  logic                                pkt_end,
  output logic                                grant_valid,
  output logic [log2_ceil(NUM_QUEUES)-1:0]    grant_queue,
  output logic [NUM_QUEUES-1:0]               grant_onehot
);

  localparam int QW = log2_ceil(NUM_QUEUES);
`ifdef DRR_STRICT_HIPRI_EN
  localparam int LAST_DRR = NUM_QUEUES - 2;
`else
  localparam int LAST_DRR = NUM_QUEUES - 1;
`endif

  state_e                   state_q, state_d;
  logic [QW-1:0]            cur_q, cur_d, cur_nxt;
  logic                     fresh_q, fresh_d;
  logic                     hipri_q, hipri_d;
  logic [LEN_WIDTH-1:0]     len_lat_q, len_lat_d;
  logic                     grant_valid_q, grant_valid_d;
  logic [QW-1:0]            grant_queue_q, grant_queue_d;
  logic [NUM_QUEUES-1:0]    grant_onehot_q, grant_onehot_d;

  logic                     ne_cur;
  logic [LEN_WIDTH-1:0]     len_cur;
  logic [QUANTUM_WIDTH-1:0] quant_cur;
  bank_op_e                 bank_op;
  logic [DEFICIT_WIDTH-1:0] bank_operand;
  logic [DEFICIT_WIDTH-1:0] def_cur;

  drr_deficit_bank #(
    .NUM_QUEUES   (NUM_QUEUES),
    .DEFICIT_WIDTH(DEFICIT_WIDTH),
    .IDX_WIDTH    (QW)
  ) u_bank (
    .clk    (axis_aclk),
    .rst    (axis_reset),
    .op     (bank_op),
    .idx    (cur_q),
    .operand(bank_operand),
    .rd_data(def_cur)
  );

  // Head-of-queue view for the queue under the scan pointer.
  always_comb begin
    ne_cur    = 1'b0;
    len_cur   = '0;
    quant_cur = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (cur_q == QW'(i)) begin
        ne_cur    = q_nonempty[i];
        len_cur   = q_pkt_len[i*LEN_WIDTH +: LEN_WIDTH];
        quant_cur = q_quantum[i*QUANTUM_WIDTH +: QUANTUM_WIDTH];
      end
    end
    cur_nxt = (cur_q == QW'(LAST_DRR)) ? '0 : cur_q + QW'(1);
  end

  // Scheduler next-state: one scan decision per cycle, one packet per grant.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    fresh_d      = fresh_q;
    hipri_d      = hipri_q;
    len_lat_d    = len_lat_q;
    bank_op      = BANK_NOP;
    bank_operand = '0;
    case (state_q)
      SCAN: begin
`ifdef DRR_STRICT_HIPRI_EN
        if (q_nonempty[NUM_QUEUES-1]) begin
          // dma jumps the queue; cur/fresh stay put so DRR resumes in place
          state_d = SERVE;
          hipri_d = 1'b1;
        end else
`endif
        if (!ne_cur) begin
          bank_op = BANK_CLR;
          cur_d   = cur_nxt;
          fresh_d = 1'b1;
        end else if (fresh_q) begin
          bank_op      = BANK_ADD;
          bank_operand = DEFICIT_WIDTH'(quant_cur);
          fresh_d      = 1'b0;
        end else if (def_cur >= DEFICIT_WIDTH'(len_cur)) begin
          len_lat_d = len_cur;
          state_d   = SERVE;
        end else begin
          cur_d   = cur_nxt;
          fresh_d = 1'b1;
        end
      end
      default: begin
        if (pkt_end) begin
          state_d = SCAN;
          hipri_d = 1'b0;
          if (!hipri_q) begin
            bank_op      = BANK_SUB;
            bank_operand = DEFICIT_WIDTH'(len_lat_q);
          end
        end
      end
    endcase
    grant_valid_d = (state_d == SERVE);
    grant_queue_d = hipri_d ? QW'(NUM_QUEUES-1) : cur_d;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      grant_onehot_d[i] = grant_valid_d && (grant_queue_d == QW'(i));
    end
  end

  // State and registered outputs; reset overrides a coincident pkt_end.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q        <= SCAN;
      cur_q          <= '0;
      fresh_q        <= 1'b1;
      hipri_q        <= 1'b0;
      len_lat_q      <= '0;
      grant_valid_q  <= 1'b0;
      grant_queue_q  <= '0;
      grant_onehot_q <= '0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      fresh_q        <= fresh_d;
      hipri_q        <= hipri_d;
      len_lat_q      <= len_lat_d;
      grant_valid_q  <= grant_valid_d;
      grant_queue_q  <= grant_queue_d;
      grant_onehot_q <= grant_onehot_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_queue  = grant_queue_q;
  assign grant_onehot = grant_onehot_q;

endmodule

// File: doc/drr_output_scheduler.md
# drr_output_scheduler

Deficit-round-robin packet scheduler controlling the output-queue mux of the PvS switch. It watches the head of each per-port output FIFO (non-empty flag plus head packet byte length) and grants one queue at a time for one whole packet. It charges each packet's length against a per-queue byte deficit, so bandwidth shares follow programmable quanta instead of plain packet-count round robin. The datapath mux uses `grant_queue` as its select and returns a `pkt_end` pulse when the last beat of the granted packet transfers.

## Interface
- `NUM_QUEUES`, 5: number of scheduled queues (nf0–nf3, dma).
- `LEN_WIDTH`, 16: width of head packet byte length (SUME tuser length field).
- `QUANTUM_WIDTH`, 16: width of per-queue quantum.
- `DEFICIT_WIDTH`, `LEN_WIDTH+1`: per-queue deficit counter width.
- `axis_aclk`  in  1  sole clock.
- `axis_reset`  in  1  synchronous, active-high reset.
- `q_nonempty`  in  NUM_QUEUES  bit i high: queue i holds at least one complete packet.
- `q_pkt_len`  in  NUM_QUEUES*LEN_WIDTH  head packet byte length of queue i, slice i; valid while `q_nonempty[i]`.
- `q_quantum`  in  NUM_QUEUES*QUANTUM_WIDTH  quantum of queue i, slice i; quasi-static.
- `pkt_end`  in  1  last beat of the granted packet accepted downstream (tvalid&tready&tlast).
- `grant_valid`  out  1  a packet grant is active.
- `grant_queue`  out  log2(NUM_QUEUES)  index of granted queue; mux select.
- `grant_onehot`  out  NUM_QUEUES  one-hot of `grant_queue`, qualified by `grant_valid`.

## Operation
- State: `SCAN` or `SERVE`. Also held: pointer `cur`, a `fresh` flag (quantum not yet credited this visit), `deficit[NUM_QUEUES]`, and `len_lat`.
- `SCAN` evaluates queue `cur` once per cycle, in priority order:
  - `!q_nonempty[cur]`: set `deficit[cur]` to 0. Advance `cur` (wrap NUM_QUEUES-1 to 0). Set `fresh` to 1.
  - `fresh`: add `q_quantum[cur]` to `deficit[cur]`, saturating at all-ones. Clear `fresh`. `cur` unchanged.
  - `deficit[cur] >= q_pkt_len[cur]`: latch the length into `len_lat` and enter `SERVE`.
  - Otherwise: keep the deficit, advance `cur`, and set `fresh` to 1.
- `SERVE`: `grant_valid`=1 and `grant_queue`=`cur`.
  - On `pkt_end`: set `deficit[cur]` to `deficit[cur]-len_lat` (never negative by construction) and return to `SCAN` with `fresh` still 0.
  - The same queue is then re-checked within the same visit.
- `pkt_end` outside `SERVE` is ignored.
- Length 0 is always satisfied and subtracts 0.
- Quantum 0 means the queue is never granted.
- A quantum change takes effect at the next credit.
- Deficit comparison is unsigned at DEFICIT_WIDTH; length and quantum are zero-extended.

## Timing
- Reset values:
  - `grant_valid`=0, `grant_queue`=0, `grant_onehot`=0.
  - State `SCAN`, `cur`=0, `fresh`=1.
  - All deficits 0, `len_lat`=0.
- Outputs are registered, with no combinational path from inputs to outputs.
- Latency: a queue arriving at `cur` with `fresh`=1 and sufficient credit is granted as follows:
  - cycle 0: credit;
  - cycle 1: compare;
  - cycle 2: `grant_valid` high.
- After `pkt_end` in cycle t:
  - `grant_valid` drops in t+1;
  - a re-grant of the same queue is possible at t+2 at the earliest.
- Idle scan with all queues empty costs 1 cycle per queue. Worst-case gap to a grant is 2*NUM_QUEUES+1 cycles per round.
- Reset during `SERVE`:
  - `grant_valid` clears the next cycle;
  - the mux and FIFOs are reset by the same signal, so no partial-packet recovery is needed.
- Reset asserted in the same cycle as `pkt_end`: reset wins.

## Configuration
- `DRR_STRICT_HIPRI_EN` defined: queue NUM_QUEUES-1 (dma) is strict priority.
  - In any `SCAN` cycle where `q_nonempty[NUM_QUEUES-1]` is high, that queue is granted, overriding the `cur` evaluation.
  - Its `pkt_end` does not touch any deficit.
  - `cur` and `fresh` are preserved, and the DRR round resumes where it stopped.
  - A packet already in `SERVE` is never preempted.
  - Queue NUM_QUEUES-1 is skipped by the DRR scan.
- Undefined: all queues, including dma, take part in DRR identically.

## Structure
- Shared package `drr_sched_pkg`: state enum (`SCAN`, `SERVE`), a log2 function, and the default width constants.
- One natural sub-module: `drr_deficit_bank`. It is a per-queue deficit register array with a single port offering saturating add, subtract, and clear operations.

## Test plan
- Reset held 2 cycles with all queues non-empty, length 64, quantum 64:
  - during reset, all outputs are 0;
  - the first grant is queue 0 with `grant_valid` high at cycle 2 after release.
- Only q2 non-empty, length 1500, quantum 500:
  - no grant for the first two q2 visits (deficit 500, then 1000);
  - the grant arrives on the third visit;
  - after `pkt_end`, `deficit[2]`=0.
- q0 and q1 backlogged, length 64, q0 quantum 128, q1 quantum 64:
  - over 30 grants the order repeats q0,q0,q1 (ratio 2:1).
- q1 length 1000, quantum 600:
  - the visit leaves deficit 600 with no grant;
  - q1 is then empty at its next visit → deficit cleared to 0;
  - when it refills, it again needs two visits.
- Edge pulses:
  - `pkt_end` pulse while `grant_valid`=0 → no state or deficit change;
  - zero-length head packet → granted and deficit unchanged.
- With `DRR_STRICT_HIPRI_EN`, q0 in `SERVE`, and q4 and q1 non-empty:
  - after q0's `pkt_end`, q4 is granted next, before q1;
  - `deficit[0]` is unaffected by q4's packet.
